// File: rtl/block_drawer_if.sv
// block_drawer_if: start/coordinate request from the loader and pixel-write stream to the VGA adapter.
`default_nettype none

interface block_drawer_if;
  logic       start;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] colour_in;
  logic [5:0] w_in;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    output start, x_in, y_in, colour_in, w_in,
    input  x_out, y_out, colour_out, plot, busy, done
  );

  modport slave (
    input  start, x_in, y_in, colour_in, w_in,
    output x_out, y_out, colour_out, plot, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/block_drawer.sv
// block_drawer: sweeps a bw x BLOCK_H rectangle into one VGA pixel write per cycle.
// Optional off-screen masking of plot is enabled by defining BLOCK_DRAWER_CLIP_EN.
`default_nettype none

module block_drawer #(
  parameter int unsigned BLOCK_H  = 4,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic           clk,
  input  logic           reset,
  block_drawer_if.slave  bus
);

`ifdef BLOCK_DRAWER_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam logic [3:0] LAST_ROW = 4'(BLOCK_H - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q;
  logic [7:0] bx_q;
  logic [6:0] by_q;
  logic [2:0] bcol_q;
  logic [5:0] bw_q;
  logic [5:0] cx_q;
  logic [3:0] cy_q;
  logic [7:0] x_out_q;
  logic [6:0] y_out_q;
  logic [2:0] colour_out_q;
  logic       plot_q;
  logic       busy_q;
  logic       done_q;

  logic [7:0] x_d;
  logic [6:0] y_d;
  logic [8:0] col_sum;
  logic [7:0] row_sum;
  logic       offscreen;
  logic       last_col;

  assign x_d       = bx_q + {2'b00, cx_q};
  assign y_d       = by_q + {3'b000, cy_q};
  // Clipping looks at the unwrapped sums so a block straddling the edge is cut, not wrapped.
  assign col_sum   = {1'b0, bx_q} + {3'b000, cx_q};
  assign row_sum   = {1'b0, by_q} + {4'b0000, cy_q};
  assign offscreen = (col_sum >= 9'(SCREEN_W)) || (row_sum >= 8'(SCREEN_H));
  assign last_col  = (cx_q == (bw_q - 6'd1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      bx_q         <= '0;
      by_q         <= '0;
      bcol_q       <= '0;
      bw_q         <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      x_out_q      <= '0;
      y_out_q      <= '0;
      colour_out_q <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      plot_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= bus.start;
          if (bus.start) begin
            bx_q    <= bus.x_in;
            by_q    <= bus.y_in;
            bcol_q  <= bus.colour_in;
            bw_q    <= bus.w_in;
            cx_q    <= '0;
            cy_q    <= '0;
            state_q <= (bus.w_in == 6'd0) ? DONE : DRAW;
          end
        end
        DRAW: begin
          x_out_q      <= x_d;
          y_out_q      <= y_d;
          colour_out_q <= bcol_q;
          plot_q       <= !(CLIP_EN && offscreen);
          if (last_col) begin
            cx_q <= '0;
            cy_q <= cy_q + 4'd1;
            if (cy_q == LAST_ROW) begin
              state_q <= DONE;
            end
          end else begin
            cx_q <= cx_q + 6'd1;
          end
        end
        DONE: begin
          // busy stays high through the done cycle and drops one cycle later unless restarted.
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.x_out      = x_out_q;
  assign bus.y_out      = y_out_q;
  assign bus.colour_out = colour_out_q;
  assign bus.plot       = plot_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_block_drawer.sv
// tb_block_drawer: directed vector table plus hand-written corner sequences for block_drawer.
`default_nettype none

module tb_block_drawer;
  localparam int BH = 4;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic [5:0] w;
    int         done_k;   // cycle after the start edge at which done is high (w*BH+1)
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  block_drawer_if bus();

  block_drawer #(.BLOCK_H(BH), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  vec_t vecs[7];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit visible(input vec_t v, input int p);
    int col;
    int row;
    col = int'(v.x) + p % int'(v.w);
    row = int'(v.y) + p / int'(v.w);
`ifdef BLOCK_DRAWER_CLIP_EN
    return (col < 160) && (row < 120);
`else
    return (col >= 0) && (row >= 0);
`endif
  endfunction

  task automatic drive(input vec_t v);
    bus.x_in      = v.x;
    bus.y_in      = v.y;
    bus.colour_in = v.c;
    bus.w_in      = v.w;
    bus.start     = 1'b1;
  endtask

  task automatic run_block(input vec_t v, input bit pre, input int inject_k,
                           input bit chain, input vec_t nv);
    int n;
    int p;
    bit ep;
    n = int'(v.w) * BH;
    if (!pre) begin
      @(negedge clk);
      drive(v);
    end
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", int'(bus.busy), 1);
    for (int k = 1; k <= n + 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      ep = 1'b0;
      if (k <= n) ep = visible(v, k - 1);
      chk("plot", int'(bus.plot), int'(ep));
      if (ep) begin
        p = k - 1;
        chk("x_out", int'(bus.x_out), (int'(v.x) + p % int'(v.w)) & 255);
        chk("y_out", int'(bus.y_out), (int'(v.y) + p / int'(v.w)) & 127);
        chk("colour_out", int'(bus.colour_out), int'(v.c));
      end
      chk("done", int'(bus.done), int'(k == v.done_k));
      chk("busy", int'(bus.busy), int'(k <= n + 1));
      if (k == n + 2 && n > 0) begin
        p = n - 1;
        chk("x_hold", int'(bus.x_out), (int'(v.x) + p % int'(v.w)) & 255);
      end
      if (k == inject_k) begin
        bus.start = 1'b1;
        bus.x_in  = 8'd40;
      end else if (k == inject_k + 1) begin
        bus.start = 1'b0;
      end
      if (chain && k == n + 1) begin
        drive(nv);
        break;
      end
    end
  endtask

  initial begin
    vec_t none;
    none = '{8'd0, 7'd0, 3'd0, 6'd0, 0};
    vecs[0] = '{8'd8,   7'd115, 3'd4, 6'd4,  17};
    vecs[1] = '{8'd0,   7'd0,   3'd7, 6'd1,  5};
    vecs[2] = '{8'd100, 7'd50,  3'd2, 6'd3,  13};
    vecs[3] = '{8'd156, 7'd118, 3'd5, 6'd8,  33};
    vecs[4] = '{8'd0,   7'd0,   3'd1, 6'd0,  1};
    vecs[5] = '{8'd250, 7'd126, 3'd6, 6'd10, 41};
    vecs[6] = '{8'd159, 7'd119, 3'd3, 6'd2,  9};

    bus.start = 1'b0;
    bus.x_in = '0;
    bus.y_in = '0;
    bus.colour_in = '0;
    bus.w_in = '0;

    repeat (3) @(negedge clk);
    chk("rst_x_out", int'(bus.x_out), 0);
    chk("rst_y_out", int'(bus.y_out), 0);
    chk("rst_colour", int'(bus.colour_out), 0);
    chk("rst_plot", int'(bus.plot), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_block(vecs[i], 1'b0, 0, 1'b0, none);

    // start pulsed mid-draw with a new column must not disturb the block in progress
    run_block(vecs[0], 1'b0, 3, 1'b0, none);
    repeat (2) @(negedge clk);
    chk("reject_idle_plot", int'(bus.plot), 0);

    // back-to-back: second start presented in the done cycle
    run_block(vecs[2], 1'b0, 0, 1'b1, vecs[1]);
    run_block(vecs[1], 1'b1, 0, 1'b0, none);

    // asynchronous reset in the middle of a draw
    @(negedge clk);
    drive(vecs[0]);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("pre_reset_plot", int'(bus.plot), 1);
    end
    #2 reset = 1'b0;
    #1;
    chk("async_x_out", int'(bus.x_out), 0);
    chk("async_y_out", int'(bus.y_out), 0);
    chk("async_colour", int'(bus.colour_out), 0);
    chk("async_plot", int'(bus.plot), 0);
    chk("async_busy", int'(bus.busy), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("held_reset_plot", int'(bus.plot), 0);
      chk("held_reset_done", int'(bus.done), 0);
    end
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("post_reset_idle_plot", int'(bus.plot), 0);
      chk("post_reset_idle_done", int'(bus.done), 0);
    end
    run_block(vecs[6], 1'b0, 0, 1'b0, none);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
